my_uart_rx: RTL
===============

// Module: my_uart_rx
// PURPOSE
//  Receiver for the 2-byte serial frame produced by the team's transmitter (idle high, start 0,
//  A[0..7] LSB first, B[0..7] LSB first, stop 1). Slots A[0]/B[0] are always sent as 0.
//  Recovers both bytes, flags framing errors, pulses rx_valid once per good or bad frame.
//  Sits at the far end of the rs232 link, feeding the AD/DA data path.
// PARAMETERS
//  CLKS_PER_BIT  1   clk_1M cycles per bit period (1 = same-rate link, >=3 = mid-bit sampling)
//  SYNC_STAGES   2   flip-flops in the rs232_rx synchronizer (>=2)
// PORTS
//  clk_1M      in   1  receive clock
//  rst         in   1  asynchronous reset, active low
//  rs232_rx    in   1  serial line, idle high
//  Arx_data    out  8  first byte of last frame (bit0 = A[0] slot as received)
//  Brx_data    out  8  second byte of last frame
//  rx_valid    out  1  one-cycle pulse: Arx_data/Brx_data/frame_err updated
//  frame_err   out  1  stop bit sampled 0 (or slot error, see CONFIGURATION); held to next frame
//  rx_busy     out  1  high from start detect until return to IDLE
// BEHAVIOUR
//  - Reset: Arx_data=0, Brx_data=0, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, synchronizer=all 1.
//  - rs232_rx passes SYNC_STAGES flops; "rxs" = synchronized line. All decisions use rxs.
//  - Bit timer cnt counts 0..CLKS_PER_BIT-1; bit index idx counts 0..15 (0-7 -> A, 8-15 -> B).
//  - Sample point: cnt == CLKS_PER_BIT/2 (integer divide; =0 when CLKS_PER_BIT=1, i.e. every cycle).
//  - IDLE: rxs==0 -> START, cnt=0, rx_busy=1. Otherwise stay.
//  - START: at sample point: CLKS_PER_BIT>=3 and rxs==1 -> false start, back to IDLE, no rx_valid;
//    else continue; at cnt==CLKS_PER_BIT-1 -> DATA, idx=0. (CLKS_PER_BIT=1: START lasts 1 cycle.)
//  - DATA: at sample point shift rxs into shadow register bit idx; at end of bit idx==15 -> STOP,
//    else idx+1. Shadow register 16 bits; Arx/Brx not touched during DATA.
//  - STOP: at sample point: Arx_data=shadow[7:0], Brx_data=shadow[15:8], frame_err=~rxs (| slot err),
//    rx_valid=1 for that one cycle; next cycle -> IDLE, rx_busy=0.
//  - Stop sampled 0 (break/garbled): data still published with frame_err=1; IDLE then needs rxs==1
//    for one cycle before a new start is accepted (no re-trigger on a held-low line).
//  - Back-to-back frames: start bit immediately after stop accepted (no gap required beyond above).
//  - Total: start detect to rx_valid = 17*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles (+SYNC_STAGES from pin).
//  - rst asserted mid-frame: immediate return to reset values, partial frame discarded.
//  - Counter widths: cnt = clog2(CLKS_PER_BIT)+1 bits, idx 4 bits; no wrap beyond defined ranges.
// CONFIGURATION
//  RX_LSB_CHECK_EN defined: A[0]/B[0] slots must sample 0; either 1 -> frame_err=1 at rx_valid,
//    and the published Arx_data[0]/Brx_data[0] are forced 0.
//  RX_LSB_CHECK_EN undefined: slots stored as received, no effect on frame_err.
// TESTING
//  1. CLKS_PER_BIT=1, frame A=0xA4 B=0x3C stop 1 -> one rx_valid, Arx=0xA4, Brx=0x3C, frame_err=0.
//  2. Two frames back-to-back (0x12/0x34 then 0xFE/0x80) -> two rx_valid pulses, 18 cycles apart, both correct.
//  3. Frame 0x55/0xAA with stop=0, line then held low 40 cycles -> one rx_valid, frame_err=1, no
//     second frame until line returns high.
//  4. CLKS_PER_BIT=16, 3-cycle low glitch on idle line -> no rx_valid, rx_busy drops within 16 cycles;
//     then valid frame 0xC8/0x0E -> received correctly.
//  5. rst low at idx=9 of a frame, released, new frame 0x66/0x22 -> only 0x66/0x22 reported.
//  6. RX_LSB_CHECK_EN, frame with A[0] slot=1 (0x81) B=0x10 -> frame_err=1, Arx=0x80; without macro
//     -> frame_err=0, Arx=0x81.

Source files
------------

// File: rtl/my_uart_rx.sv
// Two-byte frame receiver: start, A[0..7], B[0..7], stop; LSB first, idle high.
// Optional RX_LSB_CHECK_EN: A[0]/B[0] slots must be 0, else frame_err and forced 0.
module my_uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_1M,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] Arx_data,
    output logic [7:0] Brx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] SAMPLE = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam bit FALSE_CHK = (CLKS_PER_BIT >= 3);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic need_high_q, need_high_d;
    logic publish;
    logic rxs;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign rx_busy = (state_q != IDLE);

    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            sync_q      <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            need_high_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            need_high_q <= need_high_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        need_high_d = need_high_q;
        publish     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (need_high_q) begin
                    if (rxs) need_high_d = 1'b0;
                end else if (!rxs) begin
                    // the detect cycle is the first clock of the start bit
                    if (CLKS_PER_BIT == 1) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
            end
            START: begin
                if (FALSE_CHK && cnt_q == SAMPLE && rxs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == SAMPLE) shadow_d[idx_q] = rxs;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (idx_q == 4'd15) state_d = STOP;
                    else idx_d = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == SAMPLE) begin
                    publish     = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                    need_high_d = ~rxs;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            Arx_data  <= '0;
            Brx_data  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid <= publish;
            if (publish) begin
`ifdef RX_LSB_CHECK_EN
                Arx_data  <= {shadow_q[7:1], 1'b0};
                Brx_data  <= {shadow_q[15:9], 1'b0};
                frame_err <= ~rxs | shadow_q[0] | shadow_q[8];
`else
                Arx_data  <= shadow_q[7:0];
                Brx_data  <= shadow_q[15:8];
                frame_err <= ~rxs;
`endif
            end
        end
    end

endmodule
